// File: rtl/holosynth_pkg.sv
// holosynth shared types and sizing helpers.
// Holds the mixer FSM state type and the width/gain constant functions.
package holosynth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  function automatic int prod_w(input int sw, input int gw);
    return sw + gw + 1;
  endfunction

  function automatic int acc_w(input int sw, input int gw,
                               input int nv);
    return sw + gw + 1 + $clog2(nv);
  endfunction

  function automatic int unity_gain(input int gw);
    return 1 << (gw - 1);
  endfunction

endpackage

// File: rtl/holosynth_mixer_if.sv
// holosynth voice stream bundle (sample, valid, ready).
// master drives samples, slave (the mixer side) returns ready.
interface holosynth_mixer_if #(
  parameter int SAMPLE_W = 24
) (
  input logic clk
);
  logic signed [SAMPLE_W-1:0] voice_sample;
  logic                       voice_valid;
  logic                       voice_ready;

  modport master (
    input  clk,
    output voice_sample,
    output voice_valid,
    input  voice_ready
  );

  modport slave (
    input  clk,
    input  voice_sample,
    input  voice_valid,
    output voice_ready
  );
endinterface

// File: rtl/holosynth_mac.sv
// holosynth one-side multiply-accumulate, two stages.
// clk_i/rst_ni, clr_i zeroes the sum, en_i takes sample_i*gain_i, acc_o is the sum.
module holosynth_mac
  import holosynth_pkg::*;
#(
  parameter int SAMPLE_W   = 24,
  parameter int GAIN_W     = 8,
  parameter int NUM_VOICES = 32,
  localparam int PW = prod_w(SAMPLE_W, GAIN_W),
  localparam int AW = acc_w(SAMPLE_W, GAIN_W, NUM_VOICES)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic        [GAIN_W-1:0]   gain_i,
  output logic signed [AW-1:0]       acc_o
);

  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] g_ext;
  logic signed [PW-1:0] prod_d;
  logic signed [PW-1:0] prod_q;
  logic                 pv_q;
  logic signed [AW-1:0] acc_q;

  // gain is unsigned: zero-extend before the signed multiply
  always_comb begin
    s_ext  = PW'(sample_i);
    g_ext  = PW'({1'b0, gain_i});
    prod_d = s_ext * g_ext;
  end

  // a clear also drops a product still in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      pv_q <= en_i & ~clr_i;
      if (en_i) prod_q <= prod_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (pv_q) begin
      acc_q <= acc_q + AW'(prod_q);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/holosynth_mixer.sv
// holosynth stereo voice mixer with per-voice L/R gains.
// trig starts a frame; voice_* stream in; l/rsound_out, xxxx_zero, clip, overrun_cnt out.
module holosynth_mixer
  import holosynth_pkg::*;
#(
  parameter int NUM_VOICES    = 32,
  parameter int SAMPLE_W      = 24,
  parameter int GAIN_W        = 8,
  parameter int AUD_BIT_DEPTH = 24,
  localparam int IDX_W = $clog2(NUM_VOICES)
) (
  input  logic                            fpga_clk,
  input  logic                            reset_n,
  input  logic                            trig,
  input  logic signed [SAMPLE_W-1:0]      voice_sample,
  input  logic                            voice_valid,
  output logic                            voice_ready,
  input  logic                            gain_we,
  input  logic        [IDX_W-1:0]         gain_addr,
  input  logic                            gain_side,
  input  logic        [GAIN_W-1:0]        gain_data,
  output logic signed [AUD_BIT_DEPTH-1:0] lsound_out,
  output logic signed [AUD_BIT_DEPTH-1:0] rsound_out,
  output logic                            xxxx_zero,
  output logic                            clip,
  output logic        [7:0]               overrun_cnt
);

  localparam int AW = acc_w(SAMPLE_W, GAIN_W, NUM_VOICES);
  localparam int DW = AUD_BIT_DEPTH;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_W));
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_e state_q, state_d;

  logic             trig_q, trig_qq, trig_rise;
  logic [IDX_W-1:0] cnt_q;
  logic             drain_q;
  logic             accept, last, clr, abort, out_en;

  logic [GAIN_W-1:0] gain_l_q [NUM_VOICES];
  logic [GAIN_W-1:0] gain_r_q [NUM_VOICES];

  logic signed [AW-1:0] acc_l, acc_r;
  logic signed [DW-1:0] sat_l, sat_r;
  logic                 clip_l, clip_r;

  logic signed [DW-1:0] lsound_q, rsound_q;
  logic                 zero_q, clip_q;
  logic [7:0]           ovr_q;

  // trig_q is the registered copy; the edge shows one cycle late
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_q  <= 1'b0;
      trig_qq <= 1'b0;
    end else begin
      trig_q  <= trig;
      trig_qq <= trig_q;
    end
  end

  assign trig_rise = trig_q & ~trig_qq;

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (trig_rise) state_d = ACCUM;
      ACCUM: begin
        if (trig_rise)          state_d = ACCUM;
        else if (accept && last) state_d = DRAIN;
      end
      DRAIN: begin
        if (trig_rise)    state_d = ACCUM;
        else if (drain_q) state_d = OUTPUT;
      end
      OUTPUT: state_d = trig_rise ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // every edge starts a frame, so it always clears the sums
  always_comb begin
    voice_ready = (state_q == ACCUM);
    accept      = voice_ready & voice_valid;
    last        = (cnt_q == IDX_W'(NUM_VOICES - 1));
    clr         = trig_rise;
    abort       = trig_rise &
                  ((state_q == ACCUM) | (state_q == DRAIN));
    out_en      = (state_q == OUTPUT);
  end

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      if (clr)         cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + 1'b1;
      if (state_q == ACCUM)      drain_q <= 1'b0;
      else if (state_q == DRAIN) drain_q <= 1'b1;
    end
  end

  // the MAC reads gains in the accept cycle, so a
  // same-cycle write lands only for later samples
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        gain_l_q[i] <= UNITY;
        gain_r_q[i] <= UNITY;
      end
    end else if (gain_we) begin
      if (gain_side) gain_r_q[gain_addr] <= gain_data;
      else           gain_l_q[gain_addr] <= gain_data;
    end
  end

  holosynth_mac #(
    .SAMPLE_W  (SAMPLE_W),
    .GAIN_W    (GAIN_W),
    .NUM_VOICES(NUM_VOICES)
  ) u_mac_l (
    .clk_i   (fpga_clk),
    .rst_ni  (reset_n),
    .clr_i   (clr),
    .en_i    (accept & ~clr),
    .sample_i(voice_sample),
    .gain_i  (gain_l_q[cnt_q]),
    .acc_o   (acc_l)
  );

  holosynth_mac #(
    .SAMPLE_W  (SAMPLE_W),
    .GAIN_W    (GAIN_W),
    .NUM_VOICES(NUM_VOICES)
  ) u_mac_r (
    .clk_i   (fpga_clk),
    .rst_ni  (reset_n),
    .clr_i   (clr),
    .en_i    (accept & ~clr),
    .sample_i(voice_sample),
    .gain_i  (gain_r_q[cnt_q]),
    .acc_o   (acc_r)
  );

  // drop the unity-gain scaling, then clamp; msb flags clipping
  function automatic logic [DW:0] sat(
    input logic signed [AW-1:0] a
  );
    logic signed [AW-1:0] s;
    s = a >>> (GAIN_W - 1);
    if (s > MAXV)      return {1'b1, MAXV[DW-1:0]};
    else if (s < MINV) return {1'b1, MINV[DW-1:0]};
    else               return {1'b0, s[DW-1:0]};
  endfunction

  always_comb begin
    {clip_l, sat_l} = sat(acc_l);
    {clip_r, sat_r} = sat(acc_r);
  end

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      lsound_q <= '0;
      rsound_q <= '0;
      zero_q   <= 1'b0;
      clip_q   <= 1'b0;
      ovr_q    <= '0;
    end else begin
      zero_q <= out_en;
      if (out_en) begin
        lsound_q <= sat_l;
        rsound_q <= sat_r;
        clip_q   <= clip_l | clip_r;
      end
      if (abort && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end
  end

  assign lsound_out  = lsound_q;
  assign rsound_out  = rsound_q;
  assign xxxx_zero   = zero_q;
  assign clip        = clip_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_holosynth_mixer.sv
// holosynth_mixer directed bench.
// Scenario tasks with hand-computed expectations.
module tb_holosynth_mixer;

  localparam int NV = 32;
  localparam int SW = 24;
  localparam int GW = 8;
  localparam int AD = 24;
  localparam int IW = 5;

  logic          fpga_clk = 1'b0;
  logic          reset_n  = 1'b0;
  logic          trig     = 1'b0;
  logic          gain_we  = 1'b0;
  logic          gain_side = 1'b0;
  logic [IW-1:0] gain_addr = '0;
  logic [GW-1:0] gain_data = '0;
  logic [AD-1:0] lsound_out, rsound_out;
  logic          xxxx_zero, clip;
  logic [7:0]    overrun_cnt;

  holosynth_mixer_if #(.SAMPLE_W(SW)) vif (.clk(fpga_clk));

  int checks = 0;
  int fails  = 0;

  logic [SW-1:0] vals [NV];

  always #5 fpga_clk = ~fpga_clk;

  holosynth_mixer #(
    .NUM_VOICES   (NV),
    .SAMPLE_W     (SW),
    .GAIN_W       (GW),
    .AUD_BIT_DEPTH(AD)
  ) dut (
    .fpga_clk    (fpga_clk),
    .reset_n     (reset_n),
    .trig        (trig),
    .voice_sample(vif.voice_sample),
    .voice_valid (vif.voice_valid),
    .voice_ready (vif.voice_ready),
    .gain_we     (gain_we),
    .gain_addr   (gain_addr),
    .gain_side   (gain_side),
    .gain_data   (gain_data),
    .lsound_out  (lsound_out),
    .rsound_out  (rsound_out),
    .xxxx_zero   (xxxx_zero),
    .clip        (clip),
    .overrun_cnt (overrun_cnt)
  );

  task tick;
    @(posedge fpga_clk);
    #1;
  endtask

  task fill(input logic [SW-1:0] v);
    for (int i = 0; i < NV; i++) vals[i] = v;
  endtask

  task wr_gain(input logic side, input int addr,
               input logic [GW-1:0] data);
    gain_we   = 1'b1;
    gain_side = side;
    gain_addr = IW'(addr);
    gain_data = data;
    tick();
    gain_we = 1'b0;
  endtask

  task start_frame;
    int n;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    n = 0;
    while (vif.voice_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (vif.voice_ready !== 1'b1) begin
      fails++;
      $display("FAIL start_ready got=%b want=1", vif.voice_ready);
    end
  endtask

  // feeds vals[0..NV-1]; optional gain write alongside voice widx
  task feed(input int widx, input logic side,
            input int waddr, input logic [GW-1:0] wdata);
    for (int i = 0; i < NV; i++) begin
      vif.voice_valid  = 1'b1;
      vif.voice_sample = vals[i];
      if (i == widx) begin
        gain_we   = 1'b1;
        gain_side = side;
        gain_addr = IW'(waddr);
        gain_data = wdata;
      end
      tick();
      gain_we = 1'b0;
    end
    vif.voice_valid = 1'b0;
  endtask

  // called one cycle after the last acceptance; k = cycles after it
  task automatic collect(output int lat, output int np,
                         output logic [AD-1:0] l,
                         output logic [AD-1:0] r,
                         output logic c);
    lat = -1; np = 0; l = '0; r = '0; c = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (xxxx_zero === 1'b1) begin
        np++;
        if (lat < 0) begin
          lat = k; l = lsound_out; r = rsound_out; c = clip;
        end
      end
      if (k < 8) tick();
    end
  endtask

  task test_reset;
    #2;
    checks++;
    if (lsound_out !== '0 || rsound_out !== '0) begin
      fails++;
      $display("FAIL reset_out l=%h r=%h want=0", lsound_out, rsound_out);
    end
    checks++;
    if (xxxx_zero !== 1'b0 || clip !== 1'b0 ||
        overrun_cnt !== 8'd0 || vif.voice_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags z=%b c=%b o=%0d rdy=%b want=0",
               xxxx_zero, clip, overrun_cnt, vif.voice_ready);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task test_unity;
    int lat, np, busy;
    logic [AD-1:0] l, r;
    logic c;
    busy = 0;
    vif.voice_valid  = 1'b1;
    vif.voice_sample = 24'd5000;
    repeat (4) begin
      tick();
      if (vif.voice_ready !== 1'b0) busy++;
    end
    vif.voice_valid = 1'b0;
    checks++;
    if (busy != 0) begin
      fails++;
      $display("FAIL idle_ready high_cycles=%0d want=0", busy);
    end
    fill(24'd1000);
    start_frame();
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (lat != 4 || np != 1) begin
      fails++;
      $display("FAIL unity_timing lat=%0d pulses=%0d want=4/1", lat, np);
    end
    checks++;
    if (l !== 24'd32000 || r !== 24'd32000) begin
      fails++;
      $display("FAIL unity_sum l=%0d r=%0d want=32000", l, r);
    end
    checks++;
    if (c !== 1'b0 || lsound_out !== 24'd32000) begin
      fails++;
      $display("FAIL unity_hold clip=%b l=%0d want=0/32000",
               c, lsound_out);
    end
  endtask

  task test_gain_side;
    int lat, np;
    logic [AD-1:0] l, r;
    logic c;
    wr_gain(1'b0, 3, 8'd0);
    wr_gain(1'b1, 3, 8'd255);
    fill('0);
    vals[3] = 24'd4096;
    start_frame();
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (lat != 4 || l !== 24'd0 || r !== 24'd8160) begin
      fails++;
      $display("FAIL gain_side lat=%0d l=%0d r=%0d want=4/0/8160",
               lat, l, r);
    end
    wr_gain(1'b0, 3, 8'd128);
    wr_gain(1'b1, 3, 8'd128);
  endtask

  task test_clip;
    int lat, np;
    logic [AD-1:0] l, r;
    logic c;
    fill(24'h7FFFFF);
    start_frame();
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (l !== 24'h7FFFFF || r !== 24'h7FFFFF || c !== 1'b1) begin
      fails++;
      $display("FAIL clip_pos l=%h r=%h c=%b want=7fffff/1", l, r, c);
    end
    fill(24'h800000);
    start_frame();
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (l !== 24'h800000 || r !== 24'h800000 || c !== 1'b1) begin
      fails++;
      $display("FAIL clip_neg l=%h r=%h c=%b want=800000/1", l, r, c);
    end
    fill('0);
    start_frame();
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (l !== 24'd0 || r !== 24'd0 || c !== 1'b0) begin
      fails++;
      $display("FAIL clip_clear l=%h r=%h c=%b want=0/0", l, r, c);
    end
  endtask

  task test_back_to_back;
    int lat, np;
    logic [AD-1:0] l, r;
    logic c;
    fill(24'd10);
    start_frame();
    feed(-1, 1'b0, 0, '0);
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    checks++;
    if (xxxx_zero !== 1'b1 || lsound_out !== 24'd320 ||
        vif.voice_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first z=%b l=%0d rdy=%b want=1/320/1",
               xxxx_zero, lsound_out, vif.voice_ready);
    end
    fill(24'd20);
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (lat != 4 || l !== 24'd640 || r !== 24'd640 ||
        overrun_cnt !== 8'd0) begin
      fails++;
      $display("FAIL b2b_second lat=%0d l=%0d r=%0d o=%0d want=4/640/640/0",
               lat, l, r, overrun_cnt);
    end
  endtask

  task test_abort;
    int lat, np, bad;
    logic [AD-1:0] l, r;
    logic c;
    fill(24'd500);
    start_frame();
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (l !== 24'd16000 || r !== 24'd16000) begin
      fails++;
      $display("FAIL abort_pre l=%0d r=%0d want=16000", l, r);
    end
    start_frame();
    for (int i = 0; i < 10; i++) begin
      vif.voice_valid  = 1'b1;
      vif.voice_sample = 24'd1000;
      tick();
    end
    vif.voice_valid = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (xxxx_zero !== 1'b0 || vif.voice_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL abort_flow bad_cycles=%0d want=0", bad);
    end
    checks++;
    if (overrun_cnt !== 8'd1 || lsound_out !== 24'd16000 ||
        rsound_out !== 24'd16000) begin
      fails++;
      $display("FAIL abort_state o=%0d l=%0d r=%0d want=1/16000/16000",
               overrun_cnt, lsound_out, rsound_out);
    end
    fill(24'd7);
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (lat != 4 || np != 1 || l !== 24'd224 || r !== 24'd224) begin
      fails++;
      $display("FAIL abort_next lat=%0d n=%0d l=%0d r=%0d want=4/1/224",
               lat, np, l, r);
    end
  endtask

  task test_gain_race;
    int lat, np;
    logic [AD-1:0] l, r;
    logic c;
    fill('0);
    vals[0] = 24'd256;
    start_frame();
    feed(0, 1'b0, 0, 8'd64);
    collect(lat, np, l, r, c);
    checks++;
    if (l !== 24'd256 || r !== 24'd256) begin
      fails++;
      $display("FAIL race_old l=%0d r=%0d want=256/256", l, r);
    end
    start_frame();
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (l !== 24'd128 || r !== 24'd256) begin
      fails++;
      $display("FAIL race_new l=%0d r=%0d want=128/256", l, r);
    end
  endtask

  task test_reset_mid;
    int lat, np, z;
    logic [AD-1:0] l, r;
    logic c;
    fill(24'd1000);
    start_frame();
    for (int i = 0; i < 5; i++) begin
      vif.voice_valid  = 1'b1;
      vif.voice_sample = 24'd1000;
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (lsound_out !== '0 || rsound_out !== '0 || clip !== 1'b0 ||
        overrun_cnt !== 8'd0 || vif.voice_ready !== 1'b0 ||
        xxxx_zero !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid l=%0d r=%0d c=%b o=%0d rdy=%b z=%b want=0",
               lsound_out, rsound_out, clip, overrun_cnt,
               vif.voice_ready, xxxx_zero);
    end
    vif.voice_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    z = 0;
    repeat (6) begin
      tick();
      if (xxxx_zero !== 1'b0) z++;
    end
    checks++;
    if (z != 0) begin
      fails++;
      $display("FAIL rst_nozero pulses=%0d want=0", z);
    end
    start_frame();
    feed(-1, 1'b0, 0, '0);
    collect(lat, np, l, r, c);
    checks++;
    if (lat != 4 || l !== 24'd32000 || r !== 24'd32000) begin
      fails++;
      $display("FAIL rst_frame lat=%0d l=%0d r=%0d want=4/32000",
               lat, l, r);
    end
  endtask

  initial begin
    vif.voice_valid  = 1'b0;
    vif.voice_sample = '0;
    test_reset();
    test_unity();
    test_gain_side();
    test_clip();
    test_back_to_back();
    test_abort();
    test_gain_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
